// File: rtl/pipelined_adder_wrapper.sv
// Registered unsigned adder with valid/busy handshake; TYP picks a single-cycle,
// bit-serial or slice-pipelined core behind one interface.

module pipelined_adder_single #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              ivalid,
  output logic [DWIDTH-1:0] Sum,
  output logic              Carry,
  output logic              ovalid,
  output logic              busy
);
  logic [DWIDTH-1:0] a_q, b_q, sum_q;
  logic              v_q, carry_q, ovalid_q;
  logic [DWIDTH:0]   total_d;

  always_comb begin
    total_d = {1'b0, a_q} + {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_q      <= '0;
      b_q      <= '0;
      v_q      <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      v_q      <= ivalid;
      ovalid_q <= v_q;
      if (ivalid) begin
        a_q <= in1;
        b_q <= in2;
      end
      // Output register only moves on completion so Sum/Carry hold between results
      if (v_q) begin
        {carry_q, sum_q} <= total_d;
      end
    end
  end

  assign Sum    = sum_q;
  assign Carry  = carry_q;
  assign ovalid = ovalid_q;
  assign busy   = 1'b0;
endmodule

module pipelined_adder_serial #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              ivalid,
  output logic [DWIDTH-1:0] Sum,
  output logic              Carry,
  output logic              ovalid,
  output logic              busy
);
  localparam int CW = $clog2(DWIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, sacc_q, sacc_d, sum_q, sum_d;
  logic              cry_q, cry_d, carry_q, carry_d, ovalid_q, ovalid_d, busy_q, busy_d;
  logic              sbit_s, cout_s;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sacc_q   <= '0;
      cry_q    <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovalid_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sacc_q   <= sacc_d;
      cry_q    <= cry_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovalid_q <= ovalid_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sacc_d   = sacc_q;
    cry_d    = cry_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovalid_d = 1'b0;
    busy_d   = busy_q;
    sbit_s   = a_q[0] ^ b_q[0] ^ cry_q;
    cout_s   = (a_q[0] & b_q[0]) | (cry_q & (a_q[0] ^ b_q[0]));
    case (state_q)
      IDLE: begin
        if (ivalid) begin
          a_d     = in1;
          b_d     = in2;
          cry_d   = 1'b0;
          cnt_d   = CW'(DWIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Sum bits enter at the MSB so the accumulator is aligned after DWIDTH shifts
        a_d                 = a_q >> 1;
        b_d                 = b_q >> 1;
        cry_d               = cout_s;
        sacc_d              = sacc_q >> 1;
        sacc_d[DWIDTH-1]    = sbit_s;
        cnt_d               = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          sum_d    = sacc_d;
          carry_d  = cout_s;
          ovalid_d = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign Sum    = sum_q;
  assign Carry  = carry_q;
  assign ovalid = ovalid_q;
  assign busy   = busy_q;
endmodule

module pipelined_adder_pipe #(
  parameter int DWIDTH     = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              ivalid,
  output logic [DWIDTH-1:0] Sum,
  output logic              Carry,
  output logic              ovalid,
  output logic              busy
);
  localparam int NS = NUM_STAGES;
  localparam int SW = (DWIDTH + NS - 1) / NS;

  // Slice k covers bits [lo, hi); trailing slices may be empty when SW*NS overshoots
  function automatic int slice_lo(input int k);
    return (k * SW < DWIDTH) ? k * SW : DWIDTH;
  endfunction

  function automatic logic [DWIDTH:0] slice_mask(input int k);
    return ((DWIDTH + 1)'(1) << slice_lo(k + 1)) - ((DWIDTH + 1)'(1) << slice_lo(k));
  endfunction

  logic [DWIDTH-1:0] a_q [NS+1];
  logic [DWIDTH-1:0] b_q [NS+1];
  logic [DWIDTH-1:0] s_q [NS+1];
  logic              c_q [NS+1];
  logic              v_q [NS+1];
  logic [DWIDTH-1:0] a_d [NS+1];
  logic [DWIDTH-1:0] b_d [NS+1];
  logic [DWIDTH-1:0] s_d [NS+1];
  logic              c_d [NS+1];
  logic              v_d [NS+1];
  logic [DWIDTH:0]   mask_s, part_s;
  logic [DWIDTH-1:0] sum_q;
  logic              carry_q, ovalid_q;

  always_comb begin
    mask_s = '0;
    part_s = '0;
    a_d[0] = in1;
    b_d[0] = in2;
    s_d[0] = '0;
    c_d[0] = 1'b0;
    v_d[0] = ivalid;
    for (int k = 0; k < NS; k++) begin
      mask_s     = slice_mask(k);
      part_s     = ({1'b0, a_q[k]} & mask_s) + ({1'b0, b_q[k]} & mask_s)
                 + ((DWIDTH + 1)'(c_q[k]) << slice_lo(k));
      a_d[k + 1] = a_q[k] & ~mask_s[DWIDTH-1:0];
      b_d[k + 1] = b_q[k] & ~mask_s[DWIDTH-1:0];
      s_d[k + 1] = s_q[k] | (part_s[DWIDTH-1:0] & mask_s[DWIDTH-1:0]);
      c_d[k + 1] = |(part_s & ((DWIDTH + 1)'(1) << slice_lo(k + 1)));
      v_d[k + 1] = v_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k <= NS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      for (int k = 0; k <= NS; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovalid_q <= v_q[NS];
      if (v_q[NS]) begin
        sum_q   <= s_q[NS];
        carry_q <= c_q[NS];
      end
    end
  end

  assign Sum    = sum_q;
  assign Carry  = carry_q;
  assign ovalid = ovalid_q;
  assign busy   = 1'b0;
endmodule

module pipelined_adder_wrapper #(
  parameter int DWIDTH     = 8,
  parameter int TYP        = 2,
  parameter int NUM_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] in1,
  input  logic [DWIDTH-1:0] in2,
  input  logic              ivalid,
  output logic [DWIDTH-1:0] Sum,
  output logic              Carry,
  output logic              ovalid,
  output logic              busy
);
  generate
    if (TYP == 1) begin : g_serial
      pipelined_adder_serial #(.DWIDTH(DWIDTH)) u_core (
        .clk(clk), .rstn(rstn), .in1(in1), .in2(in2), .ivalid(ivalid),
        .Sum(Sum), .Carry(Carry), .ovalid(ovalid), .busy(busy)
      );
    end else if (TYP == 2) begin : g_pipe
      pipelined_adder_pipe #(.DWIDTH(DWIDTH), .NUM_STAGES(NUM_STAGES)) u_core (
        .clk(clk), .rstn(rstn), .in1(in1), .in2(in2), .ivalid(ivalid),
        .Sum(Sum), .Carry(Carry), .ovalid(ovalid), .busy(busy)
      );
    end else begin : g_single
      pipelined_adder_single #(.DWIDTH(DWIDTH)) u_core (
        .clk(clk), .rstn(rstn), .in1(in1), .in2(in2), .ivalid(ivalid),
        .Sum(Sum), .Carry(Carry), .ovalid(ovalid), .busy(busy)
      );
    end
  endgenerate
endmodule

// File: tb/tb_pipelined_adder_wrapper.sv
// Directed bench: one instance per architecture (plus a 3-stage pipe and an
// out-of-range TYP) driven from a single linear initial block.

module tb_pipelined_adder_wrapper;
  logic       clk;
  logic       rstn;
  logic [7:0] in1_0, in2_0, in1_1, in2_1, in1_2, in2_2;
  logic       iv_0, iv_1, iv_2;
  logic [7:0] sum_0, sum_1, sum_2, sum_3, sum_4;
  logic       carry_0, carry_1, carry_2, carry_3, carry_4;
  logic       ov_0, ov_1, ov_2, ov_3, ov_4;
  logic       busy_0, busy_1, busy_2, busy_3, busy_4;
  int         checks = 0;
  int         errors = 0;

  pipelined_adder_wrapper #(.DWIDTH(8), .TYP(0), .NUM_STAGES(2)) u0 (
    .clk(clk), .rstn(rstn), .in1(in1_0), .in2(in2_0), .ivalid(iv_0),
    .Sum(sum_0), .Carry(carry_0), .ovalid(ov_0), .busy(busy_0));
  pipelined_adder_wrapper #(.DWIDTH(8), .TYP(1), .NUM_STAGES(2)) u1 (
    .clk(clk), .rstn(rstn), .in1(in1_1), .in2(in2_1), .ivalid(iv_1),
    .Sum(sum_1), .Carry(carry_1), .ovalid(ov_1), .busy(busy_1));
  pipelined_adder_wrapper #(.DWIDTH(8), .TYP(2), .NUM_STAGES(2)) u2 (
    .clk(clk), .rstn(rstn), .in1(in1_2), .in2(in2_2), .ivalid(iv_2),
    .Sum(sum_2), .Carry(carry_2), .ovalid(ov_2), .busy(busy_2));
  pipelined_adder_wrapper #(.DWIDTH(8), .TYP(2), .NUM_STAGES(3)) u3 (
    .clk(clk), .rstn(rstn), .in1(in1_2), .in2(in2_2), .ivalid(iv_2),
    .Sum(sum_3), .Carry(carry_3), .ovalid(ov_3), .busy(busy_3));
  pipelined_adder_wrapper #(.DWIDTH(8), .TYP(3), .NUM_STAGES(2)) u4 (
    .clk(clk), .rstn(rstn), .in1(in1_0), .in2(in2_0), .ivalid(iv_0),
    .Sum(sum_4), .Carry(carry_4), .ovalid(ov_4), .busy(busy_4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pa [4];
    logic [7:0] pb [4];
    logic [8:0] pe [4];
    logic [7:0] ra, rb;
    int         pulses;
    int         gap;

    pa = '{8'h01, 8'h80, 8'hFF, 8'h00};
    pb = '{8'h02, 8'h80, 8'hFF, 8'h00};
    pe = '{9'h003, 9'h100, 9'h1FE, 9'h000};

    // Reset held with random stimulus
    rstn = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in1_0 = 8'($urandom_range(0, 255)); in2_0 = 8'($urandom_range(0, 255));
      in1_1 = 8'($urandom_range(0, 255)); in2_1 = 8'($urandom_range(0, 255));
      in1_2 = 8'($urandom_range(0, 255)); in2_2 = 8'($urandom_range(0, 255));
      iv_0 = 1'($urandom_range(0, 1)); iv_1 = 1'($urandom_range(0, 1));
      iv_2 = 1'($urandom_range(0, 1));
      tick();
      chk("rst_u0", {5'd0, sum_0, carry_0, ov_0, busy_0}, 16'h0);
      chk("rst_u1", {5'd0, sum_1, carry_1, ov_1, busy_1}, 16'h0);
      chk("rst_u2", {5'd0, sum_2, carry_2, ov_2, busy_2}, 16'h0);
      chk("rst_u3", {5'd0, sum_3, carry_3, ov_3, busy_3}, 16'h0);
      chk("rst_u4", {5'd0, sum_4, carry_4, ov_4, busy_4}, 16'h0);
    end
    rstn = 1'b1;
    iv_0 = 1'b0; iv_1 = 1'b0; iv_2 = 1'b0;

    // Pipelined single pair FF+01
    in1_2 = 8'hFF; in2_2 = 8'h01; iv_2 = 1'b1;
    tick();
    iv_2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("p2_ov", {15'd0, ov_2}, {15'd0, c == 3});
      chk("p2_busy", {15'd0, busy_2}, 16'h0);
      chk("p3_ov", {15'd0, ov_3}, {15'd0, c == 4});
      if (c == 3) chk("p2_res", {7'd0, carry_2, sum_2}, 16'h100);
      if (c == 4) chk("p3_res", {7'd0, carry_3, sum_3}, 16'h100);
    end
    chk("p2_hold", {7'd0, carry_2, sum_2}, 16'h100);

    // Pipelined full-throughput burst
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        in1_2 = pa[c]; in2_2 = pb[c]; iv_2 = 1'b1;
      end else begin
        iv_2 = 1'b0;
      end
      tick();
      chk("tp2_ov", {15'd0, ov_2}, {15'd0, (c >= 3) && (c <= 6)});
      chk("tp3_ov", {15'd0, ov_3}, {15'd0, (c >= 4) && (c <= 7)});
      if ((c >= 3) && (c <= 6)) chk("tp2_res", {7'd0, carry_2, sum_2}, {7'd0, pe[c-3]});
      if ((c >= 4) && (c <= 7)) chk("tp3_res", {7'd0, carry_3, sum_3}, {7'd0, pe[c-4]});
    end

    // Bit-serial A5+5B, ignored pair while busy, back-to-back 7F+01 at E0+9
    in1_1 = 8'hA5; in2_1 = 8'h5B; iv_1 = 1'b1;
    tick();
    chk("s_busy_e0", {15'd0, busy_1}, 16'h1);
    for (int c = 1; c <= 9; c++) begin
      if ((c >= 2) && (c <= 5)) begin
        in1_1 = 8'h11; in2_1 = 8'h22; iv_1 = 1'b1;
      end else if (c == 9) begin
        in1_1 = 8'h7F; in2_1 = 8'h01; iv_1 = 1'b1;
      end else begin
        iv_1 = 1'b0;
      end
      tick();
      chk("s_busy", {15'd0, busy_1}, {15'd0, c != 8});
      chk("s_ov", {15'd0, ov_1}, {15'd0, c == 8});
      if (c >= 8) chk("s_res", {7'd0, carry_1, sum_1}, 16'h100);
    end
    iv_1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("s2_busy", {15'd0, busy_1}, {15'd0, c != 8});
      chk("s2_ov", {15'd0, ov_1}, {15'd0, c == 8});
    end
    chk("s2_res", {7'd0, carry_1, sum_1}, 16'h080);

    // Bit-serial reset at E0+3 discards the operation
    in1_1 = 8'hC3; in2_1 = 8'h4D; iv_1 = 1'b1;
    tick();
    iv_1 = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    chk("mr_state", {5'd0, sum_1, carry_1, ov_1, busy_1}, 16'h0);
    rstn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("mr_quiet", {14'd0, ov_1, busy_1}, 16'h0);
    end
    in1_1 = 8'h3C; in2_1 = 8'h0F; iv_1 = 1'b1;
    tick();
    iv_1 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("mr_ov", {15'd0, ov_1}, {15'd0, c == 8});
    end
    chk("mr_res", {7'd0, carry_1, sum_1}, 16'h04B);

    // Single-cycle random pairs with idle gaps, TYP=3 alongside
    pulses = 0;
    for (int p = 0; p < 10; p++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      in1_0 = ra; in2_0 = rb; iv_0 = 1'b1;
      tick();
      iv_0 = 1'b0;
      chk("t0_busy", {15'd0, busy_0}, 16'h0);
      chk("t0_early", {15'd0, ov_0}, 16'h0);
      tick();
      if (ov_0) pulses++;
      chk("t0_ov", {15'd0, ov_0}, 16'h1);
      chk("t0_res", {7'd0, carry_0, sum_0}, {7'd0, {1'b0, ra} + {1'b0, rb}});
      chk("t3_res", {7'd0, carry_4, sum_4}, {7'd0, {1'b0, ra} + {1'b0, rb}});
      gap = $urandom_range(10, 50);
      for (int g = 0; g < gap; g++) begin
        tick();
        if (ov_0) pulses++;
      end
    end
    chk("t0_pulses", 16'(pulses), 16'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
